hs32_sram_arb: RTL and testbench



---
 rtl/hs32_sram_arb.sv | 145 ++++++++++++++
 tb/tb_hs32_sram_arb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs32_sram_arb.sv
// rtl/hs32_sram_arb.sv - single-port SRAM arbiter/sequencer between HS32 core and Wishbone slave
// One transaction at a time owns the macro: IDLE -> CMD -> (WAIT) -> RESP -> IDLE.
module hs32_sram_arb #(
  parameter int          ADDR_W   = 8,
  parameter int          MAX_WAIT = 4,
  parameter logic [31:0] WB_BASE  = 32'h3000_0000,
  parameter logic [31:0] WB_MASK  = 32'hFFFF_FC00
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              arb_en,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_mask,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [3:0]        sram_wmask0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [31:0]       sram_din0,
  input  logic [31:0]       sram_dout0
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state, state_nxt;

  logic              wb_req;
  logic              start;
  logic              pick_wb;
  logic              cur_wb;
  logic              cur_we;
  logic              enter_resp;
  logic [3:0]        wait_cnt;
  logic [31:0]       rdata;
  logic              sel_we;
  logic [3:0]        sel_mask;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  assign wb_req = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & WB_MASK) == WB_BASE);
  assign start  = (state == ST_IDLE) & arb_en & (cpu_req | wb_req);

  // CPU keeps priority until Wishbone has watched MAX_WAIT CPU grants go by.
  assign pick_wb = wb_req & (~cpu_req | (wait_cnt == 4'(MAX_WAIT)));

  assign sel_we    = pick_wb ? wbs_we_i : cpu_we;
  assign sel_mask  = pick_wb ? wbs_sel_i : cpu_mask;
  assign sel_addr  = pick_wb ? wbs_adr_i[ADDR_W+1:2] : cpu_addr;
  assign sel_wdata = pick_wb ? wbs_dat_i : cpu_wdata;

  assign enter_resp = ((state == ST_CMD) & cur_we) | (state == ST_WAIT);

  assign cpu_rdata = rdata;
  assign wbs_dat_o = rdata;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CMD;
      ST_CMD:  state_nxt = cur_we ? ST_RESP : ST_WAIT;
      ST_WAIT: state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= 4'h0;
      sram_addr0  <= '0;
      sram_din0   <= 32'h0;
      cpu_gnt     <= 1'b0;
      cpu_rvalid  <= 1'b0;
      wbs_ack_o   <= 1'b0;
      rdata       <= 32'h0;
      wait_cnt    <= 4'h0;
      cur_wb      <= 1'b0;
      cur_we      <= 1'b0;
    end else begin
      cpu_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      wbs_ack_o  <= 1'b0;

      if (start) begin
        cur_wb      <= pick_wb;
        cur_we      <= sel_we;
        sram_csb0   <= 1'b0;
        sram_web0   <= ~sel_we;
        sram_wmask0 <= sel_we ? sel_mask : 4'h0;
        sram_addr0  <= sel_addr;
        sram_din0   <= sel_wdata;
        cpu_gnt     <= ~pick_wb;
        if (pick_wb) begin
          wait_cnt <= 4'h0;
        end else if (wb_req && (wait_cnt != 4'(MAX_WAIT))) begin
          wait_cnt <= wait_cnt + 4'd1;
        end
      end

      // The macro samples its command at the end of CMD; deselect right after.
      if (state == ST_CMD) begin
        sram_csb0 <= 1'b1;
        sram_web0 <= 1'b1;
      end

      if (state == ST_WAIT) begin
        rdata <= sram_dout0;
      end

      if (enter_resp) begin
        cpu_rvalid <= ~cur_wb;
        wbs_ack_o  <= cur_wb;
      end
    end
  end

endmodule

// File: tb/tb_hs32_sram_arb.sv
// tb/tb_hs32_sram_arb.sv - self-checking bench for hs32_sram_arb with macro model and reference memory
module tb_hs32_sram_arb;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arb_en = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_addr = 8'h0;
  logic [3:0]  cpu_mask = 4'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        wbs_cyc = 1'b0;
  logic        wbs_stb = 1'b0;
  logic        wbs_we = 1'b0;
  logic [3:0]  wbs_sel = 4'h0;
  logic [31:0] wbs_adr = 32'h0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic        wbs_ack;
  logic [31:0] wbs_dat_o;
  logic        sram_csb0;
  logic        sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;

  hs32_sram_arb dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .arb_en      (arb_en),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_mask    (cpu_mask),
    .cpu_wdata   (cpu_wdata),
    .cpu_gnt     (cpu_gnt),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .wbs_cyc_i   (wbs_cyc),
    .wbs_stb_i   (wbs_stb),
    .wbs_we_i    (wbs_we),
    .wbs_sel_i   (wbs_sel),
    .wbs_adr_i   (wbs_adr),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack),
    .wbs_dat_o   (wbs_dat_o),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  always #5 clk = ~clk;

  // sky130 1RW macro behaviour: command sampled on posedge while csb0 is low.
  logic [31:0] mac_mem [256];
  logic        mem_init = 1'b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mac_mem[i] <= 32'h0;
    end else if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) mac_mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end else begin
        sram_dout0 <= mac_mem[sram_addr0];
      end
    end
  end

  int csb_cnt = 0, ack_cnt = 0, gnt_cnt = 0, rv_cnt = 0;
  logic [7:0] last_addr = 8'h0;
  always @(negedge clk) begin
    if (!sram_csb0) begin
      csb_cnt++;
      last_addr = sram_addr0;
    end
    if (wbs_ack) ack_cnt++;
    if (cpu_gnt) gnt_cnt++;
    if (cpu_rvalid) rv_cnt++;
  end

  int total = 0;
  int bad = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] exp_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts with the arbiter idle, returns with it idle again.
  task automatic do_cpu(input logic we, input logic [7:0] addr, input logic [3:0] mask,
                        input logic [31:0] wd);
    int glat, rlat, c0;
    c0 = csb_cnt;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_mask = mask; cpu_wdata = wd;
    glat = 0;
    do begin tick(); glat++; end while (!cpu_gnt && glat < 20);
    cpu_req = 1'b0;
    rlat = 0;
    do begin tick(); rlat++; end while (!cpu_rvalid && rlat < 20);
    check("cpu_gnt_lat", 32'(glat), 32'd1);
    check("cpu_rvalid_lat", 32'(glat + rlat), we ? 32'd2 : 32'd3);
    if (we) ref_mem[addr] = merge(ref_mem[addr], wd, mask);
    else exp_rdata = ref_mem[addr];
    check(we ? "cpu_wr_rdata_kept" : "cpu_rdata", cpu_rdata, exp_rdata);
    tick();
    check("cpu_rvalid_pulse", {31'h0, cpu_rvalid}, 32'h0);
    check("cpu_csb_once", 32'(csb_cnt - c0), 32'd1);
  endtask

  task automatic do_wb(input logic we, input logic [7:0] addr, input logic [3:0] sel,
                       input logic [31:0] wd, input logic hold);
    int lat, c0, a0;
    c0 = csb_cnt; a0 = ack_cnt;
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we; wbs_sel = sel;
    wbs_adr = BASE | {22'h0, addr, 2'b00}; wbs_dat_i = wd;
    lat = 0;
    do begin tick(); lat++; end while (!wbs_ack && lat < 20);
    check("wb_ack_lat", 32'(lat), we ? 32'd2 : 32'd3);
    if (we) ref_mem[addr] = merge(ref_mem[addr], wd, sel);
    else exp_rdata = ref_mem[addr];
    check("wb_dat_o", wbs_dat_o, exp_rdata);
    check("wb_macro_addr", {24'h0, last_addr}, {24'h0, addr});
    if (hold) tick();
    wbs_cyc = 1'b0; wbs_stb = 1'b0;
    if (!hold) tick();
    check("wb_ack_pulse", {31'h0, wbs_ack}, 32'h0);
    tick(); tick();
    check("wb_one_ack", 32'(ack_cnt - a0), 32'd1);
    check("wb_csb_once", 32'(csb_cnt - c0), 32'd1);
  endtask

  task automatic collide(input string tag);
    int g0, n;
    g0 = gnt_cnt; n = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'($urandom_range(0, 255));
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = BASE | 32'h48;
    do begin tick(); n++; end while (!wbs_ack && n < 80);
    check({tag, "_no_timeout"}, {31'h0, wbs_ack}, 32'h1);
    check({tag, "_cpu_grants"}, 32'(gnt_cnt - g0), 32'd4);
    exp_rdata = ref_mem[8'h12];
    check({tag, "_wb_data"}, wbs_dat_o, exp_rdata);
    cpu_req = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0;
    repeat (6) tick();
  endtask

  task automatic reset_state(input string tag);
    check({tag, "_csb"}, {31'h0, sram_csb0}, 32'h1);
    check({tag, "_web"}, {31'h0, sram_web0}, 32'h1);
    check({tag, "_strobes"}, {29'h0, cpu_gnt, cpu_rvalid, wbs_ack}, 32'h0);
    check({tag, "_rdata"}, cpu_rdata, 32'h0);
  endtask

  initial begin
    int c0, a0, g0, r0, n;
    logic we, use_wb;
    logic [7:0] ad;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

    repeat (3) tick();
    reset_state("reset");
    check("reset_wmask", {28'h0, sram_wmask0}, 32'h0);
    check("reset_addr", {24'h0, sram_addr0}, 32'h0);
    check("reset_din", sram_din0, 32'h0);
    mem_init = 1'b0;
    rst_n = 1'b1;
    tick();

    do_cpu(1'b1, 8'h12, 4'b0101, 32'hA5A5_5A5A);
    do_cpu(1'b0, 8'h12, 4'b1111, 32'h0);
    check("directed_read", cpu_rdata, 32'h00A5_005A);

    do_wb(1'b0, 8'h12, 4'hF, 32'h0, 1'b0);
    check("directed_wb_read", wbs_dat_o, 32'h00A5_005A);

    c0 = csb_cnt; a0 = ack_cnt;
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = 32'h3000_0400;
    repeat (8) tick();
    wbs_cyc = 1'b0; wbs_stb = 1'b0;
    check("decode_miss_ack", 32'(ack_cnt - a0), 32'd0);
    check("decode_miss_csb", 32'(csb_cnt - c0), 32'd0);

    collide("collide1");
    collide("collide2");

    arb_en = 1'b0;
    c0 = csb_cnt; a0 = ack_cnt; g0 = gnt_cnt;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12;
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = BASE | 32'h48;
    repeat (6) tick();
    check("arb_off_grants", 32'(gnt_cnt - g0 + ack_cnt - a0), 32'd0);
    check("arb_off_csb", 32'(csb_cnt - c0), 32'd0);
    arb_en = 1'b1;
    tick();
    check("arb_on_cpu_first", {31'h0, cpu_gnt}, 32'h1);
    cpu_req = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!wbs_ack && n < 20);
    check("arb_on_wb_served", {31'h0, wbs_ack}, 32'h1);
    wbs_cyc = 1'b0; wbs_stb = 1'b0;
    repeat (3) tick();
    exp_rdata = ref_mem[8'h12];

    do_wb(1'b1, 8'h40, 4'b1010, 32'hDEAD_BEEF, 1'b1);
    do_wb(1'b0, 8'h40, 4'hF, 32'h0, 1'b1);

    for (int k = 0; k < 40; k++) begin
      we = 1'($urandom);
      use_wb = 1'($urandom);
      ad = 8'($urandom_range(0, 15));
      if (use_wb) do_wb(we, ad, 4'($urandom), $urandom, 1'($urandom));
      else do_cpu(we, ad, 4'($urandom), $urandom);
    end

    r0 = rv_cnt; a0 = ack_cnt;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12;
    n = 0;
    do begin tick(); n++; end while (!cpu_gnt && n < 20);
    cpu_req = 1'b0;
    check("midread_csb_low", {31'h0, sram_csb0}, 32'h0);
    tick();
    rst_n = 1'b0;
    #1;
    reset_state("midread_reset");
    tick(); tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("midread_no_resp", 32'(rv_cnt - r0 + ack_cnt - a0), 32'd0);
    check("midread_rdata_cleared", cpu_rdata, 32'h0);
    exp_rdata = 32'h0;
    do_cpu(1'b0, 8'h12, 4'hF, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
